// File: rtl/systolic_collector_if.sv
// Collector bus: job control, two skewed array columns in, buffered rows out, status.
// The master side drives the job and the array columns; the slave side is the collector.
interface systolic_collector_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [7:0]        num_rows;
    logic [DATA_W-1:0] col1_data;
    logic              col1_valid;
    logic [DATA_W-1:0] col2_data;
    logic              col2_valid;
    logic [DATA_W-1:0] row_data_1;
    logic [DATA_W-1:0] row_data_2;
    logic              row_valid;
    logic              row_ready;
    logic              busy;
    logic              done;
    logic              skew_err;
    logic              ovf_err;

    modport master (
        output start, num_rows, col1_data, col1_valid, col2_data, col2_valid, row_ready,
        input  row_data_1, row_data_2, row_valid, busy, done, skew_err, ovf_err
    );

    modport slave (
        input  start, num_rows, col1_data, col1_valid, col2_data, col2_valid, row_ready,
        output row_data_1, row_data_2, row_valid, busy, done, skew_err, ovf_err
    );
endinterface

// File: rtl/systolic_collector.sv
// Deskews two systolic array columns into rows and buffers them in a small FIFO.
// Row visible one cycle after it forms; row_ready low holds the head, a full FIFO drops new rows.
module systolic_collector #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    systolic_collector_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                c1_vld_q;
    logic [DATA_W-1:0]   c1_dat_q;
    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         cnt_q;
    logic [7:0]          row_cnt_q, num_q;
    logic                skew_q, ovf_q;

    logic fifo_empty, fifo_full, pop, push, row_form, skew_evt, start_acc;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop        = !fifo_empty && bus.row_ready;
    assign start_acc  = (state_q == S_IDLE) && bus.start;
    // Column 1 is delayed one cycle so it meets column 2 of the same row.
    assign row_form   = (state_q == S_COLLECT) && c1_vld_q && bus.col2_valid
                        && (row_cnt_q != num_q);
    assign skew_evt   = (state_q == S_COLLECT) && (c1_vld_q != bus.col2_valid);
    assign push       = row_form && (!fifo_full || pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.start) state_d = (bus.num_rows == 8'd0) ? S_DONE : S_COLLECT;
            S_COLLECT: if (row_form && (row_cnt_q + 8'd1 == num_q)) state_d = S_DRAIN;
            S_DRAIN:   if (fifo_empty) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            c1_vld_q  <= 1'b0;
            c1_dat_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            row_cnt_q <= '0;
            num_q     <= '0;
            skew_q    <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            c1_vld_q <= bus.col1_valid;
            c1_dat_q <= bus.col1_data;
            if (start_acc) begin
                num_q     <= bus.num_rows;
                row_cnt_q <= '0;
                skew_q    <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                // Dropped rows still count so the job always terminates.
                if (row_form)           row_cnt_q <= row_cnt_q + 8'd1;
                if (skew_evt)           skew_q    <= 1'b1;
                if (row_form && !push)  ovf_q     <= 1'b1;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= {c1_dat_q, bus.col2_data};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.row_data_1 = mem_q[rd_ptr_q][2*DATA_W-1:DATA_W];
    assign bus.row_data_2 = mem_q[rd_ptr_q][DATA_W-1:0];
    assign bus.row_valid  = !fifo_empty;
    assign bus.busy       = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.skew_err   = skew_q;
    assign bus.ovf_err    = ovf_q;
endmodule
